// File: rtl/verificador_resultados_if.sv
// Vector/result bus between the test harness and the response checker.
interface verificador_resultados_if #(
  parameter int unsigned LARGURA = 8,
  parameter int unsigned IW      = 2
);
  logic               inicio_i;
  logic               valido_i;
  logic [LARGURA-1:0] resultado_i;
  logic [LARGURA-1:0] esperado_i;
  logic               pronto_o;
  logic               concluido_o;
  logic               aprovado_o;
  logic [7:0]         erros_o;
  logic [IW-1:0]      primeiro_erro_o;
  logic [LARGURA-1:0] assinatura_o;

  modport master (
    output inicio_i, valido_i, resultado_i, esperado_i,
    input  pronto_o, concluido_o, aprovado_o, erros_o, primeiro_erro_o, assinatura_o
  );

  modport slave (
    input  inicio_i, valido_i, resultado_i, esperado_i,
    output pronto_o, concluido_o, aprovado_o, erros_o, primeiro_erro_o, assinatura_o
  );
endinterface

// File: rtl/verificador_resultados.sv
// Self-test response checker: counts mismatches, records the first failing vector.
// Define VERIFICADOR_ASSINATURA_EN to compress accepted results into a signature.
module verificador_resultados #(
  parameter int unsigned        LARGURA     = 8,
  parameter int unsigned        NUM_VETORES = 4,
  parameter logic [LARGURA-1:0] POLINOMIO   = LARGURA'(8'h1D)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  verificador_resultados_if.slave  bus
);
  localparam int unsigned IW     = (NUM_VETORES > 1) ? $clog2(NUM_VETORES) : 1;
  localparam int unsigned EW     = 8;
  localparam logic [IW-1:0] ULTIMO = IW'(NUM_VETORES - 1);
  localparam logic [EW-1:0] ERROS_MAX = '1;

  typedef enum logic [1:0] {
    OCIOSO     = 2'd0,
    COLETANDO  = 2'd1,
    FINALIZADO = 2'd2
  } estado_t;

  estado_t       estado_q;
  logic          pronto_q;
  logic          concluido_q;
  logic          aprovado_q;
  logic [EW-1:0] erros_q;
  logic [IW-1:0] primeiro_q;
  logic [IW-1:0] indice_q;

  logic aceita_c;
  logic diverge_c;
  logic partida_c;

  assign aceita_c  = bus.valido_i & pronto_q;
  assign diverge_c = (bus.resultado_i != bus.esperado_i);
  assign partida_c = (estado_q == OCIOSO) & bus.inicio_i;

  // Run control; pronto_q is only high while collecting, so acceptance implies COLETANDO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q    <= OCIOSO;
      pronto_q    <= 1'b0;
      concluido_q <= 1'b0;
      aprovado_q  <= 1'b0;
      erros_q     <= '0;
      primeiro_q  <= '0;
      indice_q    <= '0;
    end else begin
      case (estado_q)
        OCIOSO: begin
          if (bus.inicio_i) begin
            estado_q   <= COLETANDO;
            pronto_q   <= 1'b1;
            aprovado_q <= 1'b0;
            erros_q    <= '0;
            primeiro_q <= '0;
            indice_q   <= '0;
          end
        end
        COLETANDO: begin
          if (aceita_c) begin
            if (diverge_c) begin
              if (erros_q != ERROS_MAX) erros_q <= erros_q + EW'(1);
              if (erros_q == '0)        primeiro_q <= indice_q;
            end
            indice_q <= indice_q + IW'(1);
            if (indice_q == ULTIMO) begin
              estado_q    <= FINALIZADO;
              pronto_q    <= 1'b0;
              concluido_q <= 1'b1;
            end
          end
        end
        FINALIZADO: begin
          estado_q    <= OCIOSO;
          concluido_q <= 1'b0;
          aprovado_q  <= (erros_q == '0);
        end
        default: begin
          estado_q    <= OCIOSO;
          pronto_q    <= 1'b0;
          concluido_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef VERIFICADOR_ASSINATURA_EN
  logic [LARGURA-1:0] assinatura_q;

  // Shift-left LFSR folding each accepted result into the signature.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      assinatura_q <= '0;
    end else if (partida_c) begin
      assinatura_q <= '0;
    end else if (aceita_c) begin
      assinatura_q <= {assinatura_q[LARGURA-2:0], 1'b0}
                    ^ (assinatura_q[LARGURA-1] ? POLINOMIO : '0)
                    ^ bus.resultado_i;
    end
  end

  assign bus.assinatura_o = assinatura_q;
`else
  assign bus.assinatura_o = '0;
`endif

  assign bus.pronto_o        = pronto_q;
  assign bus.concluido_o     = concluido_q;
  assign bus.aprovado_o      = aprovado_q;
  assign bus.erros_o         = erros_q;
  assign bus.primeiro_erro_o = primeiro_q;
endmodule
